// File: rtl/clk_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding, default sizes and the
// period-to-divider-threshold conversion (period = 2*T + 4).
package clk_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } stateT;

    localparam int          DEFAULT_WIDTH   = 32;
    localparam logic [31:0] DEFAULT_TIMEOUT = 32'hFFFFFF;

    // Widest counter the conversion function supports; callers zero-extend into it.
    localparam int MAX_WIDTH = 64;

    // Inverse of period = 2*T + 4 with unsigned truncation; periods below 4 saturate to 0.
    function automatic logic [MAX_WIDTH-1:0] periodToThreshold(input logic [MAX_WIDTH-1:0] period);
        if (period < MAX_WIDTH'(4)) begin
            return '0;
        end
        return (period >> 1) - MAX_WIDTH'(2);
    endfunction

endpackage

// File: rtl/clk_period_meter_sync_edge_det.sv
// Multi-flop synchroniser followed by a one-flop edge detector for an asynchronous input.
// Reusable for any slow asynchronous level entering the iClk domain.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iAsync,
    output logic oS,
    output logic oRise,
    output logic oFall
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   sDly;

    // NOTE: state flops use non-blocking assignments so every stage samples the
    // previous stage's value from before the edge; blocking here would collapse the chain.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            syncQ <= '0;
            sDly  <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], iAsync};
            sDly  <= syncQ[SYNC_STAGES-1];
        end
    end

    assign oS    = syncQ[SYNC_STAGES-1];
    assign oRise = oS & ~sDly;
    assign oFall = ~oS & sDly;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the rise-to-rise period of an asynchronous signal in iClk cycles and derives
// the matching divider threshold. Define HIGH_TIME_EN to also report the high-phase length.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TIMEOUT     = WIDTH'(DEFAULT_TIMEOUT)
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iSig,
    output logic [WIDTH-1:0] oPeriod,
    output logic [WIDTH-1:0] oThreshold,
    output logic             oValid,
    output logic             oTimeout,
    output logic [WIDTH-1:0] oHighTime
);

    stateT                state;
    logic [WIDTH-1:0]     cnt;
    logic                 sigS;
    logic                 rise;
    logic                 fall;
    logic [MAX_WIDTH-1:0] thrWide;
    logic                 unusedBits;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .iClk  (iClk),
        .iRst_n(iRst_n),
        .iAsync(iSig),
        .oS    (sigS),
        .oRise (rise),
        .oFall (fall)
    );

    // cnt holds the running period, so its threshold is ready the cycle the period closes.
    assign thrWide = periodToThreshold(MAX_WIDTH'(cnt));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            oPeriod    <= '0;
            oThreshold <= '0;
            oValid     <= 1'b0;
            oTimeout   <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt      <= WIDTH'(1);
                        oTimeout <= 1'b0;
                        state    <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise landing on the timeout cycle still counts as a valid period.
                    if (rise) begin
                        oPeriod    <= cnt;
                        oThreshold <= thrWide[WIDTH-1:0];
                        oValid     <= 1'b1;
                        cnt        <= WIDTH'(1);
                    end else if (cnt == TIMEOUT) begin
                        oTimeout <= 1'b1;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HIGH_TIME_EN
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] highLatch;

    // hcnt restarts with each period; its value at the falling edge is parked in
    // highLatch until the closing rise publishes it alongside oPeriod.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hcnt      <= '0;
            highLatch <= '0;
            oHighTime <= '0;
        end else if (rise) begin
            hcnt <= WIDTH'(1);
            if (state == MEASURE) begin
                oHighTime <= highLatch;
            end
        end else if (state == MEASURE) begin
            if (sigS) begin
                hcnt <= hcnt + WIDTH'(1);
            end
            if (fall) begin
                highLatch <= hcnt;
            end
        end
    end
`else
    assign oHighTime = '0;
`endif

    // Upper conversion bits and the level/fall taps are not needed in every build.
    assign unusedBits = &{1'b0, thrWide, sigS, fall};

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: drives square waves with known high/low
// lengths and compares each reported measurement against a period/timeout model.
module tb_clk_period_meter;

    localparam int W  = 32;
    localparam int TO = 50;
`ifdef HIGH_TIME_EN
    localparam bit HIGH_EN = 1'b1;
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    logic         iClk   = 1'b0;
    logic         iRst_n = 1'b0;
    logic         iSig   = 1'b0;
    logic [W-1:0] oPeriod;
    logic [W-1:0] oThreshold;
    logic [W-1:0] oHighTime;
    logic         oValid;
    logic         oTimeout;

    clk_period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (32'd50)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iSig      (iSig),
        .oPeriod   (oPeriod),
        .oThreshold(oThreshold),
        .oValid    (oValid),
        .oTimeout  (oTimeout),
        .oHighTime (oHighTime)
    );

    always #5 iClk = ~iClk;

    int nCmp = 0;
    int nBad = 0;
    int cyc  = 0;

    // Observations, written only by the monitor.
    int   obsPer[$];
    int   obsThr[$];
    int   obsHigh[$];
    int   obsCyc[$];
    int   obsTimeouts = 0;
    int   obsToCyc    = 0;
    logic prevTo      = 1'b0;

    // Reference model state.
    int expPer[$];
    int expHigh[$];
    int expTimeouts = 0;
    bit haveRef     = 1'b0;
    int lastRise    = 0;
    int lastHigh    = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(posedge iClk) begin
        #1;
        if (oValid) begin
            obsPer.push_back(int'(oPeriod));
            obsThr.push_back(int'(oThreshold));
            obsHigh.push_back(int'(oHighTime));
            obsCyc.push_back(cyc);
        end
        if (oTimeout && !prevTo) begin
            obsTimeouts++;
            obsToCyc = cyc;
        end
        prevTo = oTimeout;
    end

    function automatic int expThr(input int p);
        return (p < 4) ? 0 : (p / 2) - 2;
    endfunction

    // A rise closes the previous period if it came within TO cycles, otherwise the
    // meter has already timed out and this rise is merely a new reference.
    task automatic modelRise(input int h);
        if (haveRef) begin
            if (cyc - lastRise <= TO) begin
                expPer.push_back(cyc - lastRise);
                expHigh.push_back(HIGH_EN ? lastHigh : 0);
            end else begin
                expTimeouts++;
            end
        end
        haveRef  = 1'b1;
        lastRise = cyc;
        lastHigh = h;
    endtask

    // Called on a falling iClk edge; returns on a falling edge.
    task automatic pulse(input int h, input int l);
        iSig = 1'b1;
        modelRise(h);
        repeat (h) @(negedge iClk);
        iSig = 1'b0;
        repeat (l) @(negedge iClk);
    endtask

    task automatic idle(input int n);
        iSig = 1'b0;
        repeat (n) @(negedge iClk);
        if (haveRef && (cyc - lastRise) > TO + 5) begin
            expTimeouts++;
            haveRef = 1'b0;
        end
    endtask

    task automatic startTest(output int pb, output int tb);
        iSig = 1'b0;
        repeat (TO + 15) @(negedge iClk);
        haveRef = 1'b0;
        expPer.delete();
        expHigh.delete();
        expTimeouts = 0;
        pb = obsPer.size();
        tb = obsTimeouts;
    endtask

    task automatic test_reset;
        #12;
        nCmp++;
        if ({oPeriod, oThreshold, oHighTime, oValid, oTimeout} !== '0) begin
            nBad++;
            $display("FAIL reset_outputs: period=%0d thr=%0d high=%0d valid=%b timeout=%b, expected all 0",
                     oPeriod, oThreshold, oHighTime, oValid, oTimeout);
        end
        @(negedge iClk);
        iRst_n = 1'b1;
        repeat (5) @(negedge iClk);
        nCmp++;
        if ({oPeriod, oThreshold, oHighTime, oValid, oTimeout} !== '0) begin
            nBad++;
            $display("FAIL reset_idle: period=%0d thr=%0d high=%0d valid=%b timeout=%b, expected all 0",
                     oPeriod, oThreshold, oHighTime, oValid, oTimeout);
        end
    endtask

    task automatic test_divider;
        int pb, tb;
        startTest(pb, tb);
        repeat (13) pulse(5, 5);
        idle(3);
        nCmp++;
        if (obsPer.size() - pb !== expPer.size()) begin
            nBad++;
            $display("FAIL divider_count: %0d measurements, expected %0d", obsPer.size() - pb, expPer.size());
        end
        for (int i = 0; i < expPer.size() && pb + i < obsPer.size(); i++) begin
            nCmp++;
            if (obsPer[pb+i] !== expPer[i] || obsThr[pb+i] !== expThr(expPer[i]) || obsHigh[pb+i] !== expHigh[i]) begin
                nBad++;
                $display("FAIL divider_meas[%0d]: period/thr/high=%0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obsPer[pb+i], obsThr[pb+i], obsHigh[pb+i], expPer[i], expThr(expPer[i]), expHigh[i]);
            end
            if (i > 0) begin
                nCmp++;
                if (obsCyc[pb+i] - obsCyc[pb+i-1] !== 10) begin
                    nBad++;
                    $display("FAIL divider_spacing[%0d]: %0d cycles between valids, expected 10", i,
                             obsCyc[pb+i] - obsCyc[pb+i-1]);
                end
            end
        end
    endtask

    task automatic test_fastest;
        int pb, tb;
        startTest(pb, tb);
        repeat (21) pulse(1, 1);
        idle(6);
        nCmp++;
        if (obsPer.size() - pb !== expPer.size()) begin
            nBad++;
            $display("FAIL fastest_count: %0d measurements, expected %0d", obsPer.size() - pb, expPer.size());
        end
        for (int i = 0; i < expPer.size() && pb + i < obsPer.size(); i++) begin
            nCmp++;
            if (obsPer[pb+i] !== expPer[i] || obsThr[pb+i] !== expThr(expPer[i]) || obsHigh[pb+i] !== expHigh[i]) begin
                nBad++;
                $display("FAIL fastest_meas[%0d]: period/thr/high=%0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obsPer[pb+i], obsThr[pb+i], obsHigh[pb+i], expPer[i], expThr(expPer[i]), expHigh[i]);
            end
        end
    endtask

    task automatic test_timeout;
        int pb, tb, lastIdx;
        startTest(pb, tb);
        repeat (4) pulse(5, 5);
        idle(70);
        nCmp++;
        if (obsPer.size() - pb !== 3 || oTimeout !== 1'b1 || oPeriod !== 32'd10) begin
            nBad++;
            $display("FAIL timeout_hold: count=%0d timeout=%b period=%0d, expected 3/1/10",
                     obsPer.size() - pb, oTimeout, oPeriod);
        end
        lastIdx = obsPer.size() - 1;
        nCmp++;
        if (obsPer.size() == 0 || obsTimeouts - tb !== 1 || obsToCyc - obsCyc[lastIdx] !== TO) begin
            nBad++;
            $display("FAIL timeout_delay: %0d timeouts, %0d cycles after last valid, expected 1 and %0d",
                     obsTimeouts - tb, (obsPer.size() == 0) ? -1 : obsToCyc - obsCyc[lastIdx], TO);
        end
        pulse(5, 5);
        nCmp++;
        if (oTimeout !== 1'b0 || obsPer.size() - pb !== 3) begin
            nBad++;
            $display("FAIL timeout_clear: timeout=%b count=%0d, expected 0 and 3", oTimeout, obsPer.size() - pb);
        end
        pulse(5, 5);
        nCmp++;
        if (obsPer.size() - pb !== 4 || obsPer[obsPer.size()-1] !== 10) begin
            nBad++;
            $display("FAIL timeout_resume: count=%0d last period=%0d, expected 4 and 10",
                     obsPer.size() - pb, obsPer[obsPer.size()-1]);
        end
        nCmp++;
        if (obsTimeouts - tb !== expTimeouts) begin
            nBad++;
            $display("FAIL timeout_events: %0d timeouts, expected %0d", obsTimeouts - tb, expTimeouts);
        end
    endtask

    task automatic test_timeout_boundary;
        int pb, tb;
        startTest(pb, tb);
        pulse(5, 45);
        pulse(5, 46);
        pulse(5, 5);
        pulse(5, 5);
        pulse(5, 8);
        nCmp++;
        if (obsPer.size() - pb !== expPer.size() || obsTimeouts - tb !== expTimeouts) begin
            nBad++;
            $display("FAIL boundary_count: %0d measurements %0d timeouts, expected %0d and %0d",
                     obsPer.size() - pb, obsTimeouts - tb, expPer.size(), expTimeouts);
        end
        for (int i = 0; i < expPer.size() && pb + i < obsPer.size(); i++) begin
            nCmp++;
            if (obsPer[pb+i] !== expPer[i] || obsThr[pb+i] !== expThr(expPer[i]) || obsHigh[pb+i] !== expHigh[i]) begin
                nBad++;
                $display("FAIL boundary_meas[%0d]: period/thr/high=%0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obsPer[pb+i], obsThr[pb+i], obsHigh[pb+i], expPer[i], expThr(expPer[i]), expHigh[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        int pb, tb;
        startTest(pb, tb);
        repeat (3) pulse(5, 5);
        iSig = 1'b1;
        repeat (3) @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        nCmp++;
        if ({oPeriod, oThreshold, oHighTime, oValid, oTimeout} !== '0) begin
            nBad++;
            $display("FAIL midreset_outputs: period=%0d thr=%0d high=%0d valid=%b timeout=%b, expected all 0",
                     oPeriod, oThreshold, oHighTime, oValid, oTimeout);
        end
        iSig = 1'b0;
        repeat (3) @(negedge iClk);
        iRst_n  = 1'b1;
        haveRef = 1'b0;
        expPer.delete();
        expHigh.delete();
        pb = obsPer.size();
        pulse(7, 7);
        nCmp++;
        if (obsPer.size() - pb !== 0 || oPeriod !== '0) begin
            nBad++;
            $display("FAIL midreset_first_rise: %0d valids period=%0d, expected 0 and 0", obsPer.size() - pb, oPeriod);
        end
        pulse(7, 7);
        nCmp++;
        if (obsPer.size() - pb !== 1 || obsPer[obsPer.size()-1] !== 14 || obsThr[obsThr.size()-1] !== 5) begin
            nBad++;
            $display("FAIL midreset_second_rise: count=%0d period=%0d thr=%0d, expected 1/14/5",
                     obsPer.size() - pb, obsPer[obsPer.size()-1], obsThr[obsThr.size()-1]);
        end
    endtask

    task automatic test_high_time;
        int pb, tb;
        startTest(pb, tb);
        repeat (4) pulse(6, 14);
        pulse(6, 10);
        nCmp++;
        if (obsPer.size() - pb !== expPer.size()) begin
            nBad++;
            $display("FAIL hightime_count: %0d measurements, expected %0d", obsPer.size() - pb, expPer.size());
        end
        for (int i = 0; i < expPer.size() && pb + i < obsPer.size(); i++) begin
            nCmp++;
            if (obsPer[pb+i] !== expPer[i] || obsThr[pb+i] !== expThr(expPer[i]) || obsHigh[pb+i] !== expHigh[i]) begin
                nBad++;
                $display("FAIL hightime_meas[%0d]: period/thr/high=%0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obsPer[pb+i], obsThr[pb+i], obsHigh[pb+i], expPer[i], expThr(expPer[i]), expHigh[i]);
            end
        end
    endtask

    task automatic test_period_change;
        int pb, tb;
        startTest(pb, tb);
        repeat (3) pulse(5, 5);
        repeat (3) pulse(8, 8);
        pulse(4, 8);
        nCmp++;
        if (obsPer.size() - pb !== expPer.size()) begin
            nBad++;
            $display("FAIL change_count: %0d measurements, expected %0d", obsPer.size() - pb, expPer.size());
        end
        for (int i = 0; i < expPer.size() && pb + i < obsPer.size(); i++) begin
            nCmp++;
            if (obsPer[pb+i] !== expPer[i] || obsThr[pb+i] !== expThr(expPer[i]) || obsHigh[pb+i] !== expHigh[i]) begin
                nBad++;
                $display("FAIL change_meas[%0d]: period/thr/high=%0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obsPer[pb+i], obsThr[pb+i], obsHigh[pb+i], expPer[i], expThr(expPer[i]), expHigh[i]);
            end
        end
    endtask

    task automatic test_random;
        int pb, tb, h, l;
        startTest(pb, tb);
        for (int n = 0; n < 60; n++) begin
            h = $urandom_range(12, 1);
            l = ($urandom_range(7, 0) == 0) ? $urandom_range(70, 40) : $urandom_range(20, 1);
            pulse(h, l);
        end
        pulse(3, 10);
        nCmp++;
        if (obsPer.size() - pb !== expPer.size() || obsTimeouts - tb !== expTimeouts) begin
            nBad++;
            $display("FAIL random_count: %0d measurements %0d timeouts, expected %0d and %0d",
                     obsPer.size() - pb, obsTimeouts - tb, expPer.size(), expTimeouts);
        end
        for (int i = 0; i < expPer.size() && pb + i < obsPer.size(); i++) begin
            nCmp++;
            if (obsPer[pb+i] !== expPer[i] || obsThr[pb+i] !== expThr(expPer[i]) || obsHigh[pb+i] !== expHigh[i]) begin
                nBad++;
                $display("FAIL random_meas[%0d]: period/thr/high=%0d/%0d/%0d, expected %0d/%0d/%0d", i,
                         obsPer[pb+i], obsThr[pb+i], obsHigh[pb+i], expPer[i], expThr(expPer[i]), expHigh[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_fastest();
        test_timeout();
        test_timeout_boundary();
        test_mid_reset();
        test_high_time();
        test_period_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
